adc_serial_reg_receiver: RTL and testbench



---
 rtl/adc_ser_pkg.sv | 20 ++
 rtl/adc_ser_sync_edge.sv | 51 +++++
 rtl/adc_serial_reg_receiver.sv | 159 +++++++++++++++
 tb/tb_adc_serial_reg_receiver.sv | 332 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/adc_ser_pkg.sv
// rtl/adc_ser_pkg.sv - shared constants and FSM state type for the ADC serial register receiver
// Purpose: frame geometry, default header word, bit-counter saturation value, FSM states.
// Ports: none (package).
package adc_ser_pkg;
  localparam logic [11:0] HEADER_DEFAULT = 12'h001;
  localparam int FRAME_BITS = 32;
  localparam int HDR_BITS   = 12;
  localparam int ADDR_BITS  = 4;
  localparam int DATA_BITS  = 16;

  // One past a full frame: any count above FRAME_BITS is simply "too long".
  localparam logic [5:0] CNT_SAT = 6'd33;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SHIFT  = 2'd1,
    COMMIT = 2'd2,
    ERROR  = 2'd3
  } state_t;
endpackage

// File: rtl/adc_ser_sync_edge.sv
// rtl/adc_ser_sync_edge.sv - pin synchronizers and SCLK/SCS edge detectors
// Purpose: brings sclk_in, sdata_in and scs_in into the clk domain through
//   SYNC_STAGES flops (SYNC_STAGES >= 2) and derives single-cycle edge pulses.
// Ports:
//   clk        in   system clock
//   sclk_in    in   serial clock pin (asynchronous)
//   sdata_in   in   serial data pin (asynchronous)
//   scs_in     in   chip select pin, active low (asynchronous)
//   sdata_sync out  synchronized data level
//   scs_sync   out  synchronized chip-select level
//   sclk_rise  out  pulse on synced SCLK rising edge
//   scs_fall   out  pulse on synced SCS falling edge (frame start)
//   scs_rise   out  pulse on synced SCS rising edge (frame end)
module adc_ser_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic clk,
  input  logic sclk_in,
  input  logic sdata_in,
  input  logic scs_in,
  output logic sdata_sync,
  output logic scs_sync,
  output logic sclk_rise,
  output logic scs_fall,
  output logic scs_rise
);
  logic [SYNC_STAGES-1:0] r_sclk_sync;
  logic [SYNC_STAGES-1:0] r_sdata_sync;
  logic [SYNC_STAGES-1:0] r_scs_sync;
  logic                   r_sclk_prev;
  logic                   r_scs_prev;

  // The chain is deliberately not reset: clearing it while a pin sits low
  // would fabricate an SCS edge when the chain refills, turning a reset in
  // the middle of a frame into a spurious frame start.
  always_ff @(posedge clk) begin
    r_sclk_sync  <= {r_sclk_sync[SYNC_STAGES-2:0], sclk_in};
    r_sdata_sync <= {r_sdata_sync[SYNC_STAGES-2:0], sdata_in};
    r_scs_sync   <= {r_scs_sync[SYNC_STAGES-2:0], scs_in};
    r_sclk_prev  <= r_sclk_sync[SYNC_STAGES-1];
    r_scs_prev   <= r_scs_sync[SYNC_STAGES-1];
  end

  // Data travels the same depth as SCLK, so at sclk_rise sdata_sync is the
  // bit that was on the pin when SCLK rose.
  assign sdata_sync = r_sdata_sync[SYNC_STAGES-1];
  assign scs_sync   = r_scs_sync[SYNC_STAGES-1];
  assign sclk_rise  = r_sclk_sync[SYNC_STAGES-1] & ~r_sclk_prev;
  assign scs_fall   = ~r_scs_sync[SYNC_STAGES-1] & r_scs_prev;
  assign scs_rise   = r_scs_sync[SYNC_STAGES-1] & ~r_scs_prev;
endmodule

// File: rtl/adc_serial_reg_receiver.sv
// rtl/adc_serial_reg_receiver.sv - 3-wire ADC serial write-frame receiver with 16x16 register bank
// Purpose: decodes {HEADER[11:0], addr[3:0], data[15:0]} frames (MSB first,
//   framed by active-low SCS, sampled on SCLK rise) into a register bank.
// Optional: define ADC_SER_STATS_EN to add good_cnt/err_cnt saturating counters.
// Ports:
//   clk        in   system clock
//   Reset_n    in   synchronous active-low reset
//   sclk_in    in   serial clock (<= clk/4)
//   sdata_in   in   serial data
//   scs_in     in   chip select, active low
//   rd_addr    in   readback address
//   rd_data    out  reg[rd_addr], registered, write-first
//   wr_strobe  out  1-cycle pulse on committed frame
//   wr_addr    out  address of last committed write
//   wr_data    out  data of last committed write
//   frame_err  out  1-cycle pulse on aborted/malformed frame
//   busy       out  state not IDLE
//   good_cnt   out  (ADC_SER_STATS_EN) saturating committed-frame count
//   err_cnt    out  (ADC_SER_STATS_EN) saturating frame_err count
module adc_serial_reg_receiver
  import adc_ser_pkg::*;
#(
  parameter logic [11:0] HEADER      = HEADER_DEFAULT,
  parameter int          NUM_REGS    = 16,
  parameter int          SYNC_STAGES = 2
) (
  input  logic                 clk,
  input  logic                 Reset_n,
  input  logic                 sclk_in,
  input  logic                 sdata_in,
  input  logic                 scs_in,
  input  logic [ADDR_BITS-1:0] rd_addr,
  output logic [DATA_BITS-1:0] rd_data,
  output logic                 wr_strobe,
  output logic [ADDR_BITS-1:0] wr_addr,
  output logic [DATA_BITS-1:0] wr_data,
  output logic                 frame_err,
  output logic                 busy
`ifdef ADC_SER_STATS_EN
  ,
  output logic [7:0]           good_cnt,
  output logic [7:0]           err_cnt
`endif
);
  logic w_sdata_sync, w_scs_sync, w_sclk_rise, w_scs_fall, w_scs_rise;

  adc_ser_sync_edge #(.SYNC_STAGES(SYNC_STAGES)) u_sync (
    .clk        (clk),
    .sclk_in    (sclk_in),
    .sdata_in   (sdata_in),
    .scs_in     (scs_in),
    .sdata_sync (w_sdata_sync),
    .scs_sync   (w_scs_sync),
    .sclk_rise  (w_sclk_rise),
    .scs_fall   (w_scs_fall),
    .scs_rise   (w_scs_rise)
  );

  state_t                r_state, w_next;
  logic [FRAME_BITS-1:0] r_shift;
  logic [5:0]            r_cnt;
  logic [DATA_BITS-1:0]  r_regs [NUM_REGS];
  logic                  r_wr_strobe, r_frame_err;
  logic [ADDR_BITS-1:0]  r_wr_addr;
  logic [DATA_BITS-1:0]  r_wr_data, r_rd_data;

  logic                 w_hdr_bad, w_frame_ok, w_shift_en, w_commit, w_err_entry;
  logic [ADDR_BITS-1:0] w_addr;
  logic [DATA_BITS-1:0] w_data;

  // Header is judged once exactly HDR_BITS bits have arrived; SCLK is at
  // most clk/4 so the count sits at 12 for several cycles before bit 13.
  assign w_hdr_bad  = (r_cnt == 6'(HDR_BITS)) && (r_shift[HDR_BITS-1:0] != HEADER);
  // After a full frame the header occupies the top bits again; re-checking
  // it costs nothing and keeps every bit of the shift register meaningful.
  assign w_frame_ok = (r_cnt == 6'(FRAME_BITS)) &&
                      (r_shift[FRAME_BITS-1:FRAME_BITS-HDR_BITS] == HEADER);
  // SCS rising in the same cycle as SCLK wins: that bit is not taken.
  assign w_shift_en = (r_state == SHIFT) && w_sclk_rise && !w_scs_rise && !w_scs_sync;
  assign w_addr     = r_shift[DATA_BITS+ADDR_BITS-1:DATA_BITS];
  assign w_data     = r_shift[DATA_BITS-1:0];

  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE:    if (w_scs_fall) w_next = SHIFT;
      SHIFT: begin
        if (w_scs_rise)     w_next = w_frame_ok ? COMMIT : ERROR;
        else if (w_hdr_bad) w_next = ERROR;
      end
      // A new frame start seen while committing is taken straight away; the
      // scs_fall pulse would otherwise be lost by the time IDLE looks.
      COMMIT:  w_next = w_scs_fall ? SHIFT : IDLE;
      ERROR:   if (w_scs_sync) w_next = IDLE;
      default: w_next = IDLE;
    endcase
  end

  assign w_commit    = (r_state == SHIFT) && (w_next == COMMIT);
  assign w_err_entry = (r_state != ERROR) && (w_next == ERROR);

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_state     <= IDLE;
      r_shift     <= '0;
      r_cnt       <= '0;
      r_wr_strobe <= 1'b0;
      r_frame_err <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      r_rd_data   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      r_state     <= w_next;
      r_wr_strobe <= w_commit;
      r_frame_err <= w_err_entry;

      if ((w_next == SHIFT) && (r_state != SHIFT)) begin
        r_cnt <= '0;
      end else if (w_shift_en) begin
        r_shift <= {r_shift[FRAME_BITS-2:0], w_sdata_sync};
        r_cnt   <= (r_cnt == CNT_SAT) ? CNT_SAT : r_cnt + 6'd1;
      end

      if (w_commit) begin
        r_regs[w_addr] <= w_data;
        r_wr_addr      <= w_addr;
        r_wr_data      <= w_data;
      end

      if (w_commit && (w_addr == rd_addr)) r_rd_data <= w_data;
      else                                 r_rd_data <= r_regs[rd_addr];
    end
  end

  assign rd_data   = r_rd_data;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;
  assign frame_err = r_frame_err;
  assign busy      = (r_state != IDLE);

`ifdef ADC_SER_STATS_EN
  logic [7:0] r_good_cnt, r_err_cnt;

  always_ff @(posedge clk) begin
    if (!Reset_n) begin
      r_good_cnt <= '0;
      r_err_cnt  <= '0;
    end else begin
      if (w_commit && (r_good_cnt != 8'hFF))   r_good_cnt <= r_good_cnt + 8'd1;
      if (w_err_entry && (r_err_cnt != 8'hFF)) r_err_cnt  <= r_err_cnt + 8'd1;
    end
  end

  assign good_cnt = r_good_cnt;
  assign err_cnt  = r_err_cnt;
`endif
endmodule

// File: tb/tb_adc_serial_reg_receiver.sv
// tb/tb_adc_serial_reg_receiver.sv - self-checking bench for adc_serial_reg_receiver
module tb_adc_serial_reg_receiver;
  logic        clk = 1'b0;
  logic        Reset_n;
  logic        sclk_in, sdata_in, scs_in;
  logic [3:0]  rd_addr;
  logic [15:0] rd_data;
  logic        wr_strobe;
  logic [3:0]  wr_addr;
  logic [15:0] wr_data;
  logic        frame_err;
  logic        busy;
`ifdef ADC_SER_STATS_EN
  logic [7:0]  good_cnt, err_cnt;
`endif

  adc_serial_reg_receiver dut (
    .clk       (clk),
    .Reset_n   (Reset_n),
    .sclk_in   (sclk_in),
    .sdata_in  (sdata_in),
    .scs_in    (scs_in),
    .rd_addr   (rd_addr),
    .rd_data   (rd_data),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data),
    .frame_err (frame_err),
    .busy      (busy)
`ifdef ADC_SER_STATS_EN
    ,
    .good_cnt  (good_cnt),
    .err_cnt   (err_cnt)
`endif
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  logic [15:0] m_regs [16];

  int          strobe_seen = 0;
  int          err_seen    = 0;
  logic [3:0]  last_addr   = '0;
  logic [15:0] last_data   = '0;
  logic        prev_strobe = 1'b0;
  logic [15:0] post_rd     = '0;

  always @(negedge clk) begin
    if (prev_strobe) post_rd = rd_data;
    if (wr_strobe) begin
      strobe_seen++;
      last_addr = wr_addr;
      last_data = wr_data;
    end
    if (frame_err) err_seen++;
    prev_strobe = wr_strobe;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic tickn(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send_bits(input logic [63:0] v, input int n, input int hp);
    for (int i = n - 1; i >= 0; i--) begin
      sdata_in = v[i];
      sclk_in  = 1'b0;
      tickn(hp);
      sclk_in  = 1'b1;
      tickn(hp);
    end
    sclk_in = 1'b0;
  endtask

  // Reference rule: a frame writes only if it is exactly 32 bits with the
  // right header; anything else is one error and no write.
  task automatic model_frame(input logic [63:0] v, input int n,
                             output bit ew, output bit ee);
    logic [63:0] hdr;
    hdr = (n >= 12) ? ((v >> (n - 12)) & 64'hFFF) : 64'h001;
    ee  = (n != 32) || (hdr != 64'h001);
    ew  = !ee;
    if (ew) m_regs[v[19:16]] = v[15:0];
  endtask

  task automatic run_frame(input logic [63:0] v, input int n, input int hp,
                           output int ds, output int de, output bit ew, output bit ee);
    int s0, e0;
    s0 = strobe_seen;
    e0 = err_seen;
    scs_in = 1'b0;
    tickn(4);
    send_bits(v, n, hp);
    tickn(4);
    scs_in = 1'b1;
    tickn(8);
    model_frame(v, n, ew, ee);
    ds = strobe_seen - s0;
    de = err_seen - e0;
  endtask

  task automatic read_reg(input logic [3:0] a, output logic [15:0] d);
    rd_addr = a;
    tickn(2);
    d = rd_data;
  endtask

  task automatic do_reset();
    Reset_n = 1'b0;
    tickn(1);
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
  endtask

  task automatic test_reset();
    logic [15:0] d;
    Reset_n = 1'b0;
    tickn(5);
    Reset_n = 1'b1;
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    tickn(1);
    tests++;
    if ({wr_strobe, frame_err, busy} !== 3'b000) begin
      fails++;
      $display("FAIL reset_flags got %b want 000", {wr_strobe, frame_err, busy});
    end
    tests++;
    if (wr_addr !== 4'h0 || wr_data !== 16'h0) begin
      fails++;
      $display("FAIL reset_wr got %h/%h want 0/0000", wr_addr, wr_data);
    end
    read_reg(4'd9, d);
    tests++;
    if (d !== 16'h0) begin
      fails++;
      $display("FAIL reset_reg9 got %h want 0000", d);
    end
  endtask

  task automatic test_valid_write();
    int ds, de; bit ew, ee; logic [15:0] d;
    rd_addr = 4'd5;
    run_frame(64'h0015A5C3, 32, 4, ds, de, ew, ee);
    tests++;
    if (ds !== 1 || de !== 0) begin
      fails++;
      $display("FAIL valid_pulses got strobe=%0d err=%0d want 1/0", ds, de);
    end
    tests++;
    if (last_addr !== 4'd5 || last_data !== 16'hA5C3) begin
      fails++;
      $display("FAIL valid_wr got %h/%h want 5/a5c3", last_addr, last_data);
    end
    tests++;
    if (post_rd !== 16'hA5C3) begin
      fails++;
      $display("FAIL valid_write_first got %h want a5c3", post_rd);
    end
    read_reg(4'd5, d);
    tests++;
    if (d !== m_regs[5] || busy !== 1'b0) begin
      fails++;
      $display("FAIL valid_readback got %h busy=%b want %h busy=0", d, busy, m_regs[5]);
    end
  endtask

  task automatic test_bad_header();
    int s0, e0; logic [15:0] d; logic [63:0] v;
    v  = 64'h00231234;
    s0 = strobe_seen;
    e0 = err_seen;
    scs_in = 1'b0;
    tickn(4);
    send_bits(v >> 18, 14, 4);
    tickn(6);
    tests++;
    if (err_seen - e0 !== 1 || busy !== 1'b1) begin
      fails++;
      $display("FAIL badhdr_midframe got err=%0d busy=%b want 1/1", err_seen - e0, busy);
    end
    send_bits(v, 18, 4);
    tickn(4);
    scs_in = 1'b1;
    tickn(8);
    tests++;
    if (err_seen - e0 !== 1 || strobe_seen - s0 !== 0 || busy !== 1'b0) begin
      fails++;
      $display("FAIL badhdr_end got err=%0d strobe=%0d busy=%b want 1/0/0",
               err_seen - e0, strobe_seen - s0, busy);
    end
    read_reg(4'd3, d);
    tests++;
    if (d !== m_regs[3]) begin
      fails++;
      $display("FAIL badhdr_reg3 got %h want %h", d, m_regs[3]);
    end
  endtask

  task automatic test_short_long();
    int ds, de; bit ew, ee;
    run_frame(64'h001AB, 20, 4, ds, de, ew, ee);
    tests++;
    if (ds !== 0 || de !== 1) begin
      fails++;
      $display("FAIL short_frame got strobe=%0d err=%0d want 0/1", ds, de);
    end
    run_frame({30'h0, 12'h001, 22'h2ABCDE}, 34, 4, ds, de, ew, ee);
    tests++;
    if (ds !== 0 || de !== 1) begin
      fails++;
      $display("FAIL long_frame got strobe=%0d err=%0d want 0/1", ds, de);
    end
  endtask

  task automatic test_mid_frame_reset();
    int s0, e0, ds, de; bit ew, ee; logic [15:0] d;
    s0 = strobe_seen;
    e0 = err_seen;
    scs_in = 1'b0;
    tickn(4);
    send_bits(64'h001F, 16, 4);
    do_reset();
    tickn(4);
    scs_in = 1'b1;
    tickn(8);
    run_frame(64'h001FFFFF, 32, 4, ds, de, ew, ee);
    tests++;
    if (strobe_seen - s0 !== 1 || err_seen - e0 !== 0) begin
      fails++;
      $display("FAIL midreset_pulses got strobe=%0d err=%0d want 1/0",
               strobe_seen - s0, err_seen - e0);
    end
    read_reg(4'd15, d);
    tests++;
    if (d !== 16'hFFFF) begin
      fails++;
      $display("FAIL midreset_reg15 got %h want ffff", d);
    end
    read_reg(4'd5, d);
    tests++;
    if (d !== m_regs[5]) begin
      fails++;
      $display("FAIL midreset_reg5_cleared got %h want %h", d, m_regs[5]);
    end
  endtask

  task automatic test_random();
    int ds, de, n, hp, kind; bit ew, ee; logic [63:0] v; logic [3:0] a; logic [15:0] d;
    for (int k = 0; k < 24; k++) begin
      kind = $urandom_range(0, 3);
      hp   = $urandom_range(2, 5);
      case (kind)
        0: begin n = 32; v = {32'h0, 12'h001, 4'($urandom), 16'($urandom)}; end
        1: begin n = 32; v = {32'h0, 12'($urandom_range(2, 4095)), 20'($urandom)}; end
        2:  n = $urandom_range(1, 31);
        default: n = $urandom_range(33, 40);
      endcase
      if (kind >= 2) begin
        v = {$urandom, $urandom};
        v = v >> (64 - n);
        if (n >= 12 && $urandom_range(0, 3) != 0)
          v = (64'h001 << (n - 12)) | (v & ((64'd1 << (n - 12)) - 64'd1));
      end
      run_frame(v, n, hp, ds, de, ew, ee);
      tests++;
      if (ds !== int'(ew) || de !== int'(ee)) begin
        fails++;
        $display("FAIL rand_pulses[%0d] n=%0d v=%h got strobe=%0d err=%0d want %0d/%0d",
                 k, n, v, ds, de, ew, ee);
      end
      if (ew) begin
        tests++;
        if (last_addr !== v[19:16] || last_data !== v[15:0]) begin
          fails++;
          $display("FAIL rand_wr[%0d] got %h/%h want %h/%h", k, last_addr, last_data,
                   v[19:16], v[15:0]);
        end
      end
      a = 4'($urandom);
      read_reg(a, d);
      tests++;
      if (d !== m_regs[a]) begin
        fails++;
        $display("FAIL rand_read[%0d] addr=%0d got %h want %h", k, a, d, m_regs[a]);
      end
    end
  endtask

`ifdef ADC_SER_STATS_EN
  task automatic test_stats();
    int ds, de; bit ew, ee;
    do_reset();
    tickn(4);
    for (int k = 0; k < 300; k++)
      run_frame({32'h0, 12'h001, 4'(k), 16'(k * 7)}, 32, 2, ds, de, ew, ee);
    run_frame(64'h001A, 16, 2, ds, de, ew, ee);
    run_frame(64'h5, 3, 2, ds, de, ew, ee);
    tests++;
    if (good_cnt !== 8'hFF || err_cnt !== 8'd2) begin
      fails++;
      $display("FAIL stats got good=%h err=%h want ff/02", good_cnt, err_cnt);
    end
  endtask
`endif

  initial begin
    Reset_n  = 1'b0;
    sclk_in  = 1'b0;
    sdata_in = 1'b0;
    scs_in   = 1'b1;
    rd_addr  = '0;
    test_reset();
    test_valid_write();
    test_bad_header();
    test_short_long();
    test_mid_frame_reset();
    test_random();
`ifdef ADC_SER_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
